// File: rtl/td4_prog_mem_if.sv
// rtl/td4_prog_mem_if.sv - fetch, loader and status bundle for the TD4 program memory
interface td4_prog_mem_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
    logic              busy;
    logic              load_start;
    logic [DATA_W-1:0] load_data;
    logic              load_valid;
    logic              load_last;
    logic              load_ready;
    logic [ADDR_W:0]   load_count;
    logic              load_done;
    logic              err_overflow;

    modport master (
        output fetch_addr, load_start, load_data, load_valid, load_last,
        input  fetch_data, fetch_valid, busy, load_ready, load_count, load_done, err_overflow
    );

    modport slave (
        input  fetch_addr, load_start, load_data, load_valid, load_last,
        output fetch_data, fetch_valid, busy, load_ready, load_count, load_done, err_overflow
    );
endinterface

// File: rtl/td4_prog_mem.sv
// rtl/td4_prog_mem.sv - writable TD4 program memory with post-reset clear and byte-stream loader
module td4_prog_mem #(
    parameter int              ADDR_W = 4,
    parameter int              DATA_W = 8,
    parameter logic [DATA_W-1:0] FILL = '0
) (
    input  logic           clk,
    input  logic           reset,
    td4_prog_mem_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;
    logic              load_done_q, load_done_d;
    logic              err_overflow_q, err_overflow_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              xfer;
    logic              at_end;

    // Next-state logic; the single memory address is muxed by state so the array maps onto one RAM port
    always_comb begin
        state_d        = state_q;
        clr_ptr_d      = clr_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        fetch_data_d   = fetch_data_q;
        fetch_valid_d  = fetch_valid_q;
        load_count_d   = load_count_q;
        load_done_d    = 1'b0;
        err_overflow_d = err_overflow_q;
        mem_we         = 1'b0;
        mem_addr       = bus.fetch_addr;
        mem_wdata      = bus.load_data;
        xfer           = (state_q == ST_LOAD) && bus.load_valid;
        at_end         = (wr_ptr_q == LAST_ADDR);

        case (state_q)
            ST_CLEAR: begin
                mem_addr      = clr_ptr_q;
                mem_wdata     = FILL;
                mem_we        = 1'b1;
                clr_ptr_d     = clr_ptr_q + 1'b1;
                fetch_valid_d = 1'b0;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                fetch_data_d  = mem[mem_addr];
                fetch_valid_d = !bus.load_start;
                if (bus.load_start) begin
                    state_d        = ST_LOAD;
                    wr_ptr_d       = '0;
                    load_count_d   = '0;
                    err_overflow_d = 1'b0;
                end
            end
            ST_LOAD: begin
                mem_addr      = wr_ptr_q;
                fetch_valid_d = 1'b0;
                if (xfer) begin
                    mem_we       = 1'b1;
                    load_count_d = load_count_q + 1'b1;
                    if (!at_end) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                    if (bus.load_last || at_end) begin
                        state_d     = ST_RUN;
                        load_done_d = 1'b1;
                    end
                    if (at_end && !bus.load_last) begin
                        err_overflow_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Control registers; reset always restarts the clear sequence and drops any partial load
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_CLEAR;
            clr_ptr_q      <= '0;
            wr_ptr_q       <= '0;
            fetch_data_q   <= '0;
            fetch_valid_q  <= 1'b0;
            load_count_q   <= '0;
            load_done_q    <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            clr_ptr_q      <= clr_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            fetch_data_q   <= fetch_data_d;
            fetch_valid_q  <= fetch_valid_d;
            load_count_q   <= load_count_d;
            load_done_q    <= load_done_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    // Memory array write port; no reset on the storage itself, the clear sequence wipes it
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign bus.fetch_data   = fetch_data_q;
    assign bus.fetch_valid  = fetch_valid_q;
    assign bus.busy         = (state_q != ST_RUN);
    assign bus.load_ready   = (state_q == ST_LOAD);
    assign bus.load_count   = load_count_q;
    assign bus.load_done    = load_done_q;
    assign bus.err_overflow = err_overflow_q;
endmodule

// File: tb/tb_td4_prog_mem.sv
// tb/tb_td4_prog_mem.sv - randomized self-checking bench for td4_prog_mem
module tb_td4_prog_mem;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    td4_prog_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    td4_prog_mem #(.ADDR_W(AW), .DATA_W(DW), .FILL(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    int            ref_count;
    bit            ref_ovf;
    logic [DW-1:0] ld_data [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit noisy);
        int n;
        reset = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.load_start = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        ref_count = 0;
        ref_ovf   = 1'b0;
        check("rst_busy", bus.busy, 1);
        check("rst_fetch_valid", bus.fetch_valid, 0);
        check("rst_load_ready", bus.load_ready, 0);
        check("rst_load_count", bus.load_count, 0);
        check("rst_load_done", bus.load_done, 0);
        check("rst_err", bus.err_overflow, 0);
        check("rst_fetch_data", bus.fetch_data, 0);
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            bus.load_start = (noisy && n < 12) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        bus.load_start = 1'b0;
        check("clear_len", n, 16);
        check("run_entry_fetch_valid", bus.fetch_valid, 0);
        check("run_entry_load_count", bus.load_count, ref_count);
        check("run_entry_err", bus.err_overflow, ref_ovf);
        tick();
        check("run2_fetch_valid", bus.fetch_valid, 1);
        check("run2_fetch_data", bus.fetch_data, ref_mem[bus.fetch_addr]);
    endtask

    task automatic sweep;
        for (int a = 0; a < DEPTH; a++) begin
            bus.fetch_addr = AW'(a);
            tick();
            check($sformatf("sweep_data[%0d]", a), bus.fetch_data, ref_mem[a]);
            check($sformatf("sweep_valid[%0d]", a), bus.fetch_valid, 1);
        end
    endtask

    // mode 0: valid every cycle, 1: valid every other cycle, 2: random valid
    task automatic run_load(input int n, input bit use_last, input int mode);
        int words;
        bit ovf;
        int k;
        int cyc;
        int addr;
        logic v;
        words = (use_last && n <= DEPTH) ? n : DEPTH;
        ovf   = !(use_last && n <= DEPTH);
        addr  = $urandom_range(0, DEPTH - 1);
        bus.fetch_addr = AW'(addr);
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        check("start_fetch_data", bus.fetch_data, ref_mem[addr]);
        check("load_entry_ready", bus.load_ready, 1);
        check("load_entry_busy", bus.busy, 1);
        check("load_entry_fetch_valid", bus.fetch_valid, 0);
        check("load_entry_count", bus.load_count, 0);
        check("load_entry_err", bus.err_overflow, 0);
        k = 0;
        cyc = 0;
        while (k < words && cyc < 200) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (cyc % 2 == 0);
            else                v = 1'($urandom_range(0, 1));
            bus.load_valid = v;
            bus.load_data  = ld_data[k];
            bus.load_last  = use_last && (k == n - 1);
            bus.load_start = 1'($urandom_range(0, 1));
            check("ld_ready", bus.load_ready, 1);
            check("ld_done_low", bus.load_done, 0);
            tick();
            cyc++;
            if (v) begin
                ref_mem[k] = ld_data[k];
                k++;
            end
            if (k < words) check("ld_count_progress", bus.load_count, k);
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.load_start = 1'b0;
        check("ld_words_sent", k, words);
        ref_count = words;
        ref_ovf   = ovf;
        check("exit_done", bus.load_done, 1);
        check("exit_busy", bus.busy, 0);
        check("exit_ready", bus.load_ready, 0);
        check("exit_count", bus.load_count, ref_count);
        check("exit_err", bus.err_overflow, ref_ovf);
        check("exit_fetch_valid", bus.fetch_valid, 0);
        tick();
        check("post_done", bus.load_done, 0);
        check("post_fetch_valid", bus.fetch_valid, 1);
        check("post_fetch_data", bus.fetch_data, ref_mem[addr]);
    endtask

    initial begin
        reset          = 1'b0;
        bus.fetch_addr = 4'd5;
        bus.load_start = 1'b0;
        bus.load_data  = '0;
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;

        do_reset(1'b1);
        sweep();

        ld_data[0] = 8'hB7;
        ld_data[1] = 8'h01;
        ld_data[2] = 8'hE1;
        run_load(3, 1'b1, 0);
        sweep();

        for (int i = 0; i < DEPTH; i++) ld_data[i] = 8'(8'h10 + i);
        run_load(16, 1'b0, 1);
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hFF;
        check("word17_ready", bus.load_ready, 0);
        tick();
        bus.load_valid = 1'b0;
        check("word17_count", bus.load_count, 16);
        check("word17_err", bus.err_overflow, 1);
        sweep();

        ld_data[0] = 8'($urandom);
        ld_data[1] = 8'($urandom);
        run_load(2, 1'b1, 2);
        sweep();

        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 8'($urandom);
            tick();
        end
        bus.load_valid = 1'b0;
        check("midload_count", bus.load_count, 2);
        do_reset(1'b0);
        sweep();

        repeat (4) begin
            for (int i = 0; i < DEPTH; i++) ld_data[i] = 8'($urandom);
            run_load($urandom_range(1, 20), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
            sweep();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/td4_prog_mem.md
Name: td4_prog_mem

Overview:
- Parametrised, writable program memory for the TD4 core; successor to the fixed 16x8 instruction ROM.
- Core fetches through a registered read port with 1-cycle latency.
- A byte-stream loader port, valid/ready handshake, rewrites the program at run time.
- An internal sequencer wipes the array after reset and asserts `busy` to hold the core while contents are invalid.

Parameters:
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, instruction word width.
- FILL, 0, value written to every word during the post-reset clear.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_addr  in  ADDR_W  core program-counter address.
- fetch_data  out  DATA_W  registered word at the fetch_addr of the previous cycle.
- fetch_valid  out  1  fetch_data is a valid RUN-mode read.
- busy  out  1  core must stall (CLEAR or LOAD active).
- load_start  in  1  request to enter LOAD; sampled in RUN only.
- load_data  in  DATA_W  word to write.
- load_valid  in  1  load_data is presented.
- load_last  in  1  qualifies the current transfer as the final word.
- load_ready  out  1  loader accepts a word this cycle.
- load_count  out  ADDR_W+1  words written in the current or last load.
- load_done  out  1  one-cycle pulse when LOAD ends.
- err_overflow  out  1  sticky; the load hit DEPTH words without load_last.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state=CLEAR, clr_ptr=0, wr_ptr=0.
  - fetch_data=0, fetch_valid=0, busy=1, load_ready=0.
  - load_count=0, load_done=0, err_overflow=0.
  - Reset asserted mid-CLEAR or mid-LOAD restarts CLEAR; any partially loaded program is discarded.
- State CLEAR:
  - Each cycle: mem[clr_ptr]<=FILL, clr_ptr++.
  - The cycle that writes clr_ptr=DEPTH-1 moves to RUN, so CLEAR lasts exactly DEPTH cycles.
  - busy=1, fetch_valid=0, load_ready=0; load_start is ignored.
- State RUN:
  - Every cycle: fetch_data<=mem[fetch_addr].
  - fetch_valid=1 from the second RUN cycle onward, i.e. once the first RUN read has registered.
  - busy=0, load_ready=0.
  - load_start=1 moves to LOAD next cycle, sets wr_ptr=0 and load_count=0, clears err_overflow. The fetch is still performed in that cycle.
- State LOAD:
  - busy=1, load_ready=1, fetch_valid=0; fetch_data holds its last value.
  - Transfer occurs when load_valid&&load_ready: mem[wr_ptr]<=load_data, wr_ptr++, load_count++.
  - Exit on a transfer with load_last=1: next state RUN, load_done=1 for exactly one cycle (the first RUN cycle).
  - Exit on a transfer at wr_ptr=DEPTH-1 with load_last=0: same exit as above, and err_overflow<=1. load_count=DEPTH; no pointer wrap, no further words accepted.
  - Transfer at wr_ptr=DEPTH-1 with load_last=1: normal exit, err_overflow stays 0.
  - load_start is ignored while in LOAD.
  - load_valid=0 cycles stall without side effects; there is no timeout.
- Words above the last written address keep their previous contents after a short load; they are not re-cleared.
- Read-during-write: cannot occur, because fetches are suppressed in CLEAR and LOAD.
- Width rules:
  - load_count saturates naturally at DEPTH (ADDR_W+1 bits, never wraps).
  - fetch_addr is used unmodified; no out-of-range case exists.
- Memory is inferable as a single-port synchronous RAM with one write/read address mux: clr_ptr, wr_ptr or fetch_addr by state.

Test Plan (ADDR_W=4, DATA_W=8, FILL=0):
- Reset for 1 cycle, then hold fetch_addr=5 -> busy=1 for exactly 16 cycles. After that, fetch_valid rises one cycle after RUN entry with fetch_data=0x00. Sweeping addresses 0..15 returns 0x00.
- In RUN, pulse load_start and stream 0xB7,0x01,0xE1 with load_last on 0xE1 -> load_ready=1 during LOAD, load_done pulses once, load_count=3, err_overflow=0. Fetch of addr 0,1,2 returns 0xB7,0x01,0xE1 with 1-cycle latency; addr 3 returns 0x00.
- Load of 16 words 0x10..0x1F with load_valid toggling every other cycle and no load_last -> auto exit after the 16th transfer, load_count=16, err_overflow=1. Addr 15 returns 0x1F. A 17th load_valid word is not accepted (load_ready=0).
- Mid-load (after 2 of 5 words) assert reset -> CLEAR runs 16 cycles, then all addresses read 0x00, load_count=0, err_overflow=0.
- load_start pulsed during CLEAR and during LOAD -> no effect on state; load_start asserted on the same cycle as a RUN fetch -> that fetch's data is still registered.
- Second load after an overflow load: pulse load_start -> err_overflow clears on LOAD entry. Load 2 words with load_last -> load_count=2; addresses 2..15 retain the previous 0x12..0x1F.
